// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: digit count, scan states
// and the leading-zero blanking rule.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // Digit k (k > 0) goes dark when blanking is on and it and every digit to its left are zero.
    function automatic logic lz_blanked(input logic [15:0] val, input logic [1:0] k, input logic en);
        logic zero_left;
        case (k)
            2'd1:    zero_left = (val[15:4] == 12'h000);
            2'd2:    zero_left = (val[15:8] == 8'h00);
            2'd3:    zero_left = (val[15:12] == 4'h0);
            default: zero_left = 1'b0;
        endcase
        return en && zero_left;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: value/control from the datapath, scan outputs to the decoder and anodes.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [15:0]           value;
    logic                  load;
    logic [NUM_DIGITS-1:0] dp_in;
    logic                  blank_lz;
    logic [3:0]            hex;
    logic [NUM_DIGITS-1:0] anode;
    logic                  dp_n;
    logic                  blank;

    modport master (
        output value, load, dp_in, blank_lz,
        input  hex, anode, dp_n, blank
    );

    modport slave (
        input  value, load, dp_in, blank_lz,
        output hex, anode, dp_n, blank
    );

endinterface

// File: rtl/seg7_scan_driver_slot_timer.sv
// Slot timer: counts DIV cycles per digit slot and steps the digit index 0..3.
module slot_timer #(
    parameter int DIV   = 100000,
    parameter int GUARD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] digit,
    output logic       slot_start,
    output logic       drive_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_AT = CW'(GUARD);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            digit <= '0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign slot_start  = (cnt == '0);
    assign drive_start = (cnt == GUARD_AT);

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver: shadow-registered value, per-slot dead time,
// leading-zero blanking; feeds hex to an external hextosegment decoder.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int GUARD = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    seg7_scan_driver_if.slave   bus
);

    logic [15:0]           shadow_val;
    logic [NUM_DIGITS-1:0] shadow_dp;
    state_t                state;
    logic [1:0]            digit;
    logic                  slot_start;
    logic                  drive_start;
    logic                  dig_blank;

    slot_timer #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_slot_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit       (digit),
        .slot_start  (slot_start),
        .drive_start (drive_start)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (bus.load) begin
            shadow_val <= bus.value;
            shadow_dp  <= bus.dp_in;
        end
    end

    assign dig_blank = lz_blanked(shadow_val, digit, bus.blank_lz);

    // Digit data is captured once at DRIVE entry so a mid-slot load never alters a lit digit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_GUARD;
            bus.hex   <= '0;
            bus.anode <= ANODE_OFF;
            bus.dp_n  <= 1'b1;
            bus.blank <= 1'b1;
        end else begin
            case (state)
                S_GUARD: begin
                    if (drive_start) begin
                        state     <= S_DRIVE;
                        bus.hex   <= shadow_val[4*digit +: 4];
                        bus.anode <= dig_blank ? ANODE_OFF : ~(4'b0001 << digit);
                        bus.blank <= dig_blank;
                        bus.dp_n  <= dig_blank | ~shadow_dp[digit];
                    end
                end
                S_DRIVE: begin
                    if (slot_start) begin
                        state     <= S_GUARD;
                        bus.anode <= ANODE_OFF;
                        bus.blank <= 1'b1;
                        bus.dp_n  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIV=8, GUARD=2) with a cycle-indexed reference
// model feeding a scoreboard queue.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int DIV   = 8;
    localparam int GUARD = 2;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] anode;
        logic       dp_n;
        logic       blank;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   n     = 0;
    exp_t sb[$];

    // Reference state: shadow contents and the digit data latched at the last DRIVE entry.
    logic [15:0] m_val;
    logic [3:0]  m_dpv;
    logic [3:0]  m_hex;
    logic        m_bl;
    logic        m_dp;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    function automatic logic model_lz(input logic [15:0] v, input int d, input logic en);
        logic z;
        z = 1'b1;
        for (int k = d; k < 4; k++) z = z & (v[4*k +: 4] == 4'h0);
        return en && (d != 0) && z;
    endfunction

    // One clock: predict output after edge n, push it, clock, pop and compare.
    task automatic tick();
        int   pos;
        int   d;
        exp_t e;
        pos = n % DIV;
        d   = (n / DIV) % 4;
        if (pos == GUARD) begin
            m_hex = m_val[4*d +: 4];
            m_bl  = model_lz(m_val, d, bus.blank_lz);
            m_dp  = m_dpv[d];
        end
        e.hex = m_hex;
        if (pos >= GUARD && !m_bl) begin
            e.anode = ~(4'b0001 << d);
            e.dp_n  = ~m_dp;
            e.blank = 1'b0;
        end else begin
            e.anode = 4'b1111;
            e.dp_n  = 1'b1;
            e.blank = 1'b1;
        end
        if (bus.load) begin
            m_val = bus.value;
            m_dpv = bus.dp_in;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 4'h1, 4'h0);
        end else begin
            e = sb.pop_front();
            check("hex",   bus.hex,   e.hex);
            check("anode", bus.anode, e.anode);
            check("dp_n",  {3'b000, bus.dp_n},  {3'b000, e.dp_n});
            check("blank", {3'b000, bus.blank}, {3'b000, e.blank});
        end
        bus.load = 1'b0;
        n++;
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_hex",   bus.hex,   4'h0);
        check("rst_anode", bus.anode, 4'b1111);
        check("rst_dp_n",  {3'b000, bus.dp_n},  4'h1);
        check("rst_blank", {3'b000, bus.blank}, 4'h1);
        reset_n = 1'b1;
        n     = 0;
        m_val = '0;
        m_dpv = '0;
        m_hex = '0;
        m_bl  = 1'b0;
        m_dp  = 1'b0;
        sb.delete();
    endtask

    initial begin
        bus.value    = 16'h0000;
        bus.load     = 1'b0;
        bus.dp_in    = 4'b0000;
        bus.blank_lz = 1'b0;

        // Reset, then more than one frame of scan timing with all-zero shadow.
        do_reset(3);
        run(40);

        // Plain hex, no blanking: F, A, 2, 1 across the four digits.
        bus.value = 16'h12AF;
        bus.load  = 1'b1;
        run(40);

        // Leading-zero blanking, then value zero shows only digit 0.
        bus.value    = 16'h0005;
        bus.blank_lz = 1'b1;
        bus.load     = 1'b1;
        run(32);
        bus.value = 16'h0000;
        bus.load  = 1'b1;
        run(32);

        // Decimal point on digit 2 only.
        bus.blank_lz = 1'b0;
        bus.value    = 16'h1234;
        bus.dp_in    = 4'b0100;
        bus.load     = 1'b1;
        run(32);

        // Mid-slot load at cnt=5 of digit 1: lit digit keeps 1, digit 2 shows 2.
        bus.dp_in = 4'b0000;
        bus.value = 16'h1111;
        bus.load  = 1'b1;
        run(1);
        while (n % 32 != DIV + 5) tick();
        bus.value = 16'h2222;
        bus.load  = 1'b1;
        run(40);

        // Reset during digit 2 DRIVE, then scan restarts at digit 0.
        while (n % 32 != 2 * DIV + 4) tick();
        do_reset(1);
        bus.value = 16'h12AF;
        bus.load  = 1'b1;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
